// File: rtl/cpu_mem_arb_pkg.sv
// cpu_mem_arb_pkg: shared constants for the CPU instruction/data memory arbiter.
//   - owner tags stored in the outstanding-request FIFO
//   - grant state encodings of the arbiter
//   - SRAM-like transfer size encodings
package cpu_mem_arb_pkg;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } grant_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Hold state that locks the grant onto the given owner.
  function automatic grant_state_e hold_state(input logic own);
    grant_state_e st;
    if (own == OWN_DATA) begin
      st = HOLD_D;
    end else begin
      st = HOLD_I;
    end
    return st;
  endfunction

endpackage

// File: rtl/arb_owner_fifo.sv
// arb_owner_fifo: 1-bit wide, DEPTH-entry synchronous FIFO holding the owner
// tag of every accepted-but-unanswered memory request, in issue order.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset (empties the FIFO)
//   push, push_tag     write a tag (ignored while full)
//   pop                drop the head entry (ignored while empty)
//   full, empty, head  status and oldest tag
module arb_owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] tag_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Pointer advance with explicit wrap so DEPTH=1 also works.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == PW'(DEPTH - 1)) begin
      n = PW'(0);
    end else begin
      n = p + PW'(1);
    end
    return n;
  endfunction

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == CW'(0));
  assign head      = tag_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Tag storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_r    <= {DEPTH{1'b0}};
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else begin
      if (push_ok_s) begin
        tag_r[wr_ptr_r] <= push_tag;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: merges the core's instruction-fetch and data SRAM-like
// request ports onto one SRAM-like memory port, and routes each mem_data_ok
// back to the master that issued the matching request (issue order).
// Ports:
//   clk, resetn                       clock, asynchronous active-low reset
//   inst_* / data_* request inputs    req, wr, size, wstrb, addr, wdata
//   inst_* / data_* response outputs  addr_ok, data_ok, rdata
//   mem_* request outputs             req, wr, size, wstrb, addr, wdata
//   mem_addr_ok, mem_data_ok, mem_rdata  memory accept / response / read data
//   resp_err                          sticky: response seen with nothing outstanding
// Build option: define CPU_MEM_ARB_RR_EN for round-robin arbitration in FREE;
// otherwise data has fixed priority over inst.
module cpu_mem_arbiter
  import cpu_mem_arb_pkg::*;
#(
  parameter int OST_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        resp_err
);

  grant_state_e state_r;
  logic         grant_s;
  logic         grant_req_s;
  logic         accept_s;
  logic         rsp_valid_s;
  logic         fifo_full_s;
  logic         fifo_empty_s;
  logic         fifo_head_s;
  logic         resp_err_r;
`ifdef CPU_MEM_ARB_RR_EN
  logic         last_win_r;
`endif

  // Grant selection: locked while holding, arbitrated in FREE.
  always_comb begin
    grant_s = OWN_INST;
    case (state_r)
      HOLD_I: grant_s = OWN_INST;
      HOLD_D: grant_s = OWN_DATA;
      FREE: begin
        if (data_req && inst_req) begin
`ifdef CPU_MEM_ARB_RR_EN
          grant_s = ~last_win_r;
`else
          grant_s = OWN_DATA;
`endif
        end else if (data_req) begin
          grant_s = OWN_DATA;
        end else begin
          grant_s = OWN_INST;
        end
      end
      default: grant_s = OWN_INST;
    endcase
  end

  // Request mux from the granted master.
  always_comb begin
    if (grant_s == OWN_DATA) begin
      grant_req_s = data_req;
      mem_wr      = data_wr;
      mem_size    = data_size;
      mem_wstrb   = data_wstrb;
      mem_addr    = data_addr;
      mem_wdata   = data_wdata;
    end else begin
      grant_req_s = inst_req;
      mem_wr      = inst_wr;
      mem_size    = inst_size;
      mem_wstrb   = inst_wstrb;
      mem_addr    = inst_addr;
      mem_wdata   = inst_wdata;
    end
  end

  // Handshakes are forced low while reset is asserted, independent of inputs.
  // A full FIFO blocks the request even if a pop happens this cycle.
  assign mem_req      = resetn && grant_req_s && !fifo_full_s;
  assign accept_s     = mem_req && mem_addr_ok;
  assign inst_addr_ok = accept_s && (grant_s == OWN_INST);
  assign data_addr_ok = accept_s && (grant_s == OWN_DATA);

  // A response with nothing outstanding is dropped (and flagged below).
  assign rsp_valid_s  = resetn && mem_data_ok && !fifo_empty_s;
  assign inst_data_ok = rsp_valid_s && (fifo_head_s == OWN_INST);
  assign data_data_ok = rsp_valid_s && (fifo_head_s == OWN_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign resp_err     = resp_err_r;

  arb_owner_fifo #(
    .DEPTH (OST_DEPTH)
  ) u_owner_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (accept_s),
    .push_tag (grant_s),
    .pop      (rsp_valid_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .head     (fifo_head_s)
  );

  // Grant state: lock onto a granted-but-unaccepted master until it is accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= FREE;
    end else begin
      case (state_r)
        FREE: begin
          if (grant_req_s && !accept_s) begin
            state_r <= hold_state(grant_s);
          end else begin
            state_r <= FREE;
          end
        end
        HOLD_I, HOLD_D: begin
          if (accept_s) begin
            state_r <= FREE;
          end else begin
            state_r <= state_r;
          end
        end
        default: state_r <= FREE;
      endcase
    end
  end

  // Sticky spurious-response flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_err_r <= 1'b0;
    end else if (mem_data_ok && fifo_empty_s) begin
      resp_err_r <= 1'b1;
    end else begin
      resp_err_r <= resp_err_r;
    end
  end

`ifdef CPU_MEM_ARB_RR_EN
  // Last winner; resets to DATA so inst wins the first conflict.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_win_r <= OWN_DATA;
    end else if (accept_s) begin
      last_win_r <= grant_s;
    end else begin
      last_win_r <= last_win_r;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: table-driven cycle vectors plus hand-written reset and
// arbitration sequences for cpu_mem_arbiter (OST_DEPTH = 2).
module tb_cpu_mem_arbiter;
  import cpu_mem_arb_pkg::*;

  localparam logic [31:0] INST_ADDR  = 32'h1C00_0000;
  localparam logic [31:0] DATA_ADDR  = 32'h8000_0010;
  localparam logic [31:0] DATA_WDATA = 32'h1234_5678;

  logic        clk;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        resp_err;

  int n_total = 0;
  int n_pass  = 0;

  cpu_mem_arbiter #(.OST_DEPTH(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic ireq, dreq, aok, dok;
    logic e_req, e_own, e_iaok, e_daok, e_idok, e_ddok, e_err;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(input logic ireq, input logic dreq, input logic aok,
                              input logic dok, input logic e_req, input logic e_own,
                              input logic e_iaok, input logic e_daok, input logic e_idok,
                              input logic e_ddok, input logic e_err);
    vec_t v;
    v.ireq = ireq; v.dreq = dreq; v.aok = aok; v.dok = dok;
    v.e_req = e_req; v.e_own = e_own; v.e_iaok = e_iaok; v.e_daok = e_daok;
    v.e_idok = e_idok; v.e_ddok = e_ddok; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input logic ireq, input logic dreq, input logic aok,
                       input logic dok, input logic [31:0] rdata);
    inst_req    = ireq;
    data_req    = dreq;
    mem_addr_ok = aok;
    mem_data_ok = dok;
    mem_rdata   = rdata;
  endtask

  logic exp_own_seq[4];

  initial begin
    // Fixed request fields: inst word read, data word write.
    inst_wr = 1'b0; inst_size = SZ_W; inst_wstrb = 4'h0;
    inst_addr = INST_ADDR; inst_wdata = 32'h0000_0000;
    data_wr = 1'b1; data_size = SZ_W; data_wstrb = 4'hF;
    data_addr = DATA_ADDR; data_wdata = DATA_WDATA;

    //        ireq dreq aok  dok   req  own  iaok daok idok ddok err
    vecs[0]  = mk(1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0); // single inst fetch
    vecs[1]  = mk(1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0);
    vecs[2]  = mk(1'b1,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0); // conflict: data first
    vecs[3]  = mk(1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0);
    vecs[4]  = mk(1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0); // resp DATA
    vecs[5]  = mk(1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0); // resp INST
    vecs[6]  = mk(1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0); // inst stalled
    vecs[7]  = mk(1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0); // data arrives, no steal
    vecs[8]  = mk(1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0);
    vecs[9]  = mk(1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0); // held inst accepted
    vecs[10] = mk(1'b0,1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0); // push+pop same cycle
    vecs[11] = mk(1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0);
    vecs[12] = mk(1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0); // fill FIFO
    vecs[13] = mk(1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0);
    vecs[14] = mk(1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0); // full: mem_req low
    vecs[15] = mk(1'b1,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0); // pop, no lookahead
    vecs[16] = mk(1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0); // accept next cycle
    vecs[17] = mk(1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0);
    vecs[18] = mk(1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0);
    vecs[19] = mk(1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0); // spurious response
    vecs[20] = mk(1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1); // resp_err sticky

`ifdef CPU_MEM_ARB_RR_EN
    exp_own_seq[0] = OWN_INST; exp_own_seq[1] = OWN_DATA;
    exp_own_seq[2] = OWN_INST; exp_own_seq[3] = OWN_DATA;
`else
    exp_own_seq[0] = OWN_DATA; exp_own_seq[1] = OWN_DATA;
    exp_own_seq[2] = OWN_DATA; exp_own_seq[3] = OWN_DATA;
`endif

    // Reset with active inputs: handshakes forced low, rdata passes through.
    resetn = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    #3;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    chk("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_inst_rdata", inst_rdata, 32'hDEAD_BEEF);
    chk("rst_data_rdata", data_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
    resetn = 1'b1;

    // Vector table: one cycle per entry, combinational outputs sampled mid-cycle.
    for (int i = 0; i < 21; i++) begin
      logic [31:0] rd;
      @(negedge clk);
      rd = 32'hA500_0000 | 32'(i);
      drive(vecs[i].ireq, vecs[i].dreq, vecs[i].aok, vecs[i].dok, rd);
      #1;
      chk($sformatf("v%0d_mem_req", i), {31'd0, mem_req}, {31'd0, vecs[i].e_req});
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_own ? DATA_ADDR : INST_ADDR);
        chk($sformatf("v%0d_mem_wr_wstrb", i), {27'd0, mem_wr, mem_wstrb},
            vecs[i].e_own ? 32'h0000_001F : 32'h0000_0000);
      end
      chk($sformatf("v%0d_inst_addr_ok", i), {31'd0, inst_addr_ok}, {31'd0, vecs[i].e_iaok});
      chk($sformatf("v%0d_data_addr_ok", i), {31'd0, data_addr_ok}, {31'd0, vecs[i].e_daok});
      chk($sformatf("v%0d_inst_data_ok", i), {31'd0, inst_data_ok}, {31'd0, vecs[i].e_idok});
      chk($sformatf("v%0d_data_data_ok", i), {31'd0, data_data_ok}, {31'd0, vecs[i].e_ddok});
      chk($sformatf("v%0d_resp_err", i), {31'd0, resp_err}, {31'd0, vecs[i].e_err});
      chk($sformatf("v%0d_rdata", i), inst_rdata ^ data_rdata ^ rd, rd);
    end

    // resp_err clears only on reset.
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("err_cleared_by_reset", {31'd0, resp_err}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Reset mid-transaction discards the outstanding tag.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0000);
    #1;
    chk("mid_accept", {31'd0, inst_addr_ok}, 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000);
    #1;
    chk("mid_no_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
    #1;
    chk("mid_resp_err", {31'd0, resp_err}, 32'd1);

    // Both masters requesting continuously, memory answering every cycle.
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b1, (k > 0), 32'h0000_0000);
      #1;
      chk($sformatf("arb%0d_data_addr_ok", k), {31'd0, data_addr_ok}, {31'd0, exp_own_seq[k]});
      chk($sformatf("arb%0d_inst_addr_ok", k), {31'd0, inst_addr_ok}, {31'd0, ~exp_own_seq[k]});
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
